// File: rtl/jedro_1_pkg.sv
// Shared definitions for the jedro_1 core: opcode and funct3/funct7 codes,
// the ALU operation encoding, and the datapath width.
package jedro_1_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_SLLI  = 3'b001;
  localparam logic [2:0] F3_SLTI  = 3'b010;
  localparam logic [2:0] F3_SLTIU = 3'b011;
  localparam logic [2:0] F3_XORI  = 3'b100;
  localparam logic [2:0] F3_SRXI  = 3'b101;  // SRLI / SRAI, split by funct7
  localparam logic [2:0] F3_ORI   = 3'b110;
  localparam logic [2:0] F3_ANDI  = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_SRA  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_OR,
    ALU_AND,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_LUI
  } alu_op_e;

endpackage

// File: rtl/jedro_1_decoder.sv
// ID stage: decodes LUI and the OP-IMM group, reads rs1 (with forwarding from
// EX), builds the immediate and registers everything for EX. An unsupported
// word raises the sticky illegal_instr_ro and blocks all later decodes.
// Ports:
//   clk, rst                     clock, async active-high reset
//   valid, instr                 fetched word and its valid flag
//   rs1_addr / rs1_data          regfile read port
//   ex_valid, ex_rd, ex_result   instruction currently in EX, for forwarding
//   valid_ro .. imm_ro           registered ID/EX payload
//   illegal_instr_ro             sticky illegal-instruction flag
module jedro_1_decoder
  import jedro_1_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] instr,
  output logic [4:0]            rs1_addr,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic                  ex_valid,
  input  logic [4:0]            ex_rd,
  input  logic [DATA_WIDTH-1:0] ex_result,
  output logic                  valid_ro,
  output alu_op_e               alu_op_ro,
  output logic [4:0]            rd_ro,
  output logic [DATA_WIDTH-1:0] rs1_data_ro,
  output logic [DATA_WIDTH-1:0] imm_ro,
  output logic                  illegal_instr_ro
);

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic                  legal;
  logic                  dec_en;
  alu_op_e               alu_op;
  logic [DATA_WIDTH-1:0] imm;
  logic [DATA_WIDTH-1:0] rs1_val;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rs1_addr = instr[19:15];

  // Once an illegal word has been seen nothing further is decoded.
  assign dec_en = valid && !illegal_instr_ro;

  // The EX result is written at the same edge this read is registered, so
  // the regfile still holds the stale value; take the EX result instead.
  assign rs1_val = (ex_valid && (ex_rd != 5'd0) && (ex_rd == rs1_addr)) ? ex_result : rs1_data;

  always_comb begin
    alu_op = ALU_ADD;
    imm    = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    legal  = 1'b0;
    case (opcode)
      OPC_LUI: begin
        alu_op = ALU_LUI;
        imm    = {instr[31:12], 12'b0};
        legal  = 1'b1;
      end
      OPC_OP_IMM: begin
        case (funct3)
          F3_ADDI:  begin alu_op = ALU_ADD;  legal = 1'b1; end
          F3_SLTI:  begin alu_op = ALU_SLT;  legal = 1'b1; end
          F3_SLTIU: begin alu_op = ALU_SLTU; legal = 1'b1; end
          F3_XORI:  begin alu_op = ALU_XOR;  legal = 1'b1; end
          F3_ORI:   begin alu_op = ALU_OR;   legal = 1'b1; end
          F3_ANDI:  begin alu_op = ALU_AND;  legal = 1'b1; end
          F3_SLLI:  begin alu_op = ALU_SLL;  legal = (funct7 == F7_ZERO); end
          F3_SRXI: begin
            if (funct7 == F7_ZERO) begin
              alu_op = ALU_SRL;
              legal  = 1'b1;
            end else if (funct7 == F7_SRA) begin
              alu_op = ALU_SRA;
              legal  = 1'b1;
            end
          end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  // ID -> EX boundary: control with reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_ro         <= 1'b0;
      illegal_instr_ro <= 1'b0;
    end else begin
      valid_ro         <= dec_en && legal;
      illegal_instr_ro <= illegal_instr_ro || (dec_en && !legal);
    end
  end

  // ID -> EX boundary: data, qualified by valid_ro
  always_ff @(posedge clk) begin
    alu_op_ro   <= alu_op;
    rd_ro       <= instr[11:7];
    rs1_data_ro <= rs1_val;
    imm_ro      <= imm;
  end

endmodule

// File: rtl/jedro_1_regfile.sv
// Integer register file: 32 x DATA_WIDTH, one combinational read port and one
// synchronous write port. x0 is never written, so it always reads as zero.
// Ports:
//   clk, rst       clock, async active-high reset (clears every register)
//   raddr / rdata  read port
//   we/waddr/wdata write port, takes effect at the rising edge
module jedro_1_regfile
  import jedro_1_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [DATA_WIDTH-1:0] wdata
);

  logic [DATA_WIDTH-1:0] regfile [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regfile[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regfile[waddr] <= wdata;
    end
  end

  assign rdata = regfile[raddr];

endmodule

// File: rtl/jedro_1_core.sv
// jedro_1 core: 3-stage in-order RV32I subset (LUI + OP-IMM).
//   IF    : PC drives the synchronous instruction ROM, word returns next cycle
//   ID    : decoder_inst (decode, rs1 read with forwarding, immediate)
//   EX/WB : inline ALU, result written to regfile_inst at the next edge
// Ports:
//   clk_i, rstn_i    clock; reset is asynchronous and asserted HIGH
//   imem_addr_o      instruction byte address (= PC)
//   imem_data_i      instruction word, one cycle after imem_addr_o
//   dmem_*           data-memory port, idle (outputs tied to zero)
module jedro_1_core #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_data_i,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  output logic [3:0]            dmem_we_o,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i
);
  import jedro_1_pkg::*;

  logic [ADDR_WIDTH-1:0] pc_p0;
  logic                  vld_p0;
  logic [4:0]            rs1_addr;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic                  dec_valid;
  alu_op_e               dec_alu_op;
  logic [4:0]            dec_rd;
  logic [DATA_WIDTH-1:0] dec_rs1_data;
  logic [DATA_WIDTH-1:0] dec_imm;
  logic                  illegal_instr;
  logic [DATA_WIDTH-1:0] ex_result;
  logic                  unused_dmem;

  function automatic logic [DATA_WIDTH-1:0] alu(input alu_op_e op,
                                                input logic [DATA_WIDTH-1:0] a,
                                                input logic [DATA_WIDTH-1:0] b);
    logic signed [DATA_WIDTH-1:0] sa;
    logic signed [DATA_WIDTH-1:0] sb;
    logic [4:0]                   shamt;
    logic [DATA_WIDTH-1:0]        res;
    sa    = a;
    sb    = b;
    shamt = b[4:0];
    res   = '0;
    case (op)
      ALU_ADD:  res = a + b;
      ALU_SLT:  res = {{(DATA_WIDTH-1){1'b0}}, (sa < sb)};
      ALU_SLTU: res = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      ALU_XOR:  res = a ^ b;
      ALU_OR:   res = a | b;
      ALU_AND:  res = a & b;
      ALU_SLL:  res = a << shamt;
      ALU_SRL:  res = a >> shamt;
      ALU_SRA:  res = sa >>> shamt;
      ALU_LUI:  res = b;
      default:  res = '0;
    endcase
    return res;
  endfunction

  // IF stage: PC advances every cycle until an illegal instruction is seen.
  // vld_p0 marks the ROM word as trustworthy from one cycle after reset.
  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      pc_p0  <= '0;
      vld_p0 <= 1'b0;
    end else begin
      if (!illegal_instr) pc_p0 <= pc_p0 + ADDR_WIDTH'(4);
      vld_p0 <= !illegal_instr;
    end
  end

  assign imem_addr_o = pc_p0;

  // ID stage
  jedro_1_decoder decoder_inst (
    .clk              (clk_i),
    .rst              (rstn_i),
    .valid            (vld_p0),
    .instr            (imem_data_i),
    .rs1_addr         (rs1_addr),
    .rs1_data         (rs1_data),
    .ex_valid         (dec_valid),
    .ex_rd            (dec_rd),
    .ex_result        (ex_result),
    .valid_ro         (dec_valid),
    .alu_op_ro        (dec_alu_op),
    .rd_ro            (dec_rd),
    .rs1_data_ro      (dec_rs1_data),
    .imm_ro           (dec_imm),
    .illegal_instr_ro (illegal_instr)
  );

  // EX/WB stage
  assign ex_result = alu(dec_alu_op, dec_rs1_data, dec_imm);

  jedro_1_regfile regfile_inst (
    .clk   (clk_i),
    .rst   (rstn_i),
    .raddr (rs1_addr),
    .rdata (rs1_data),
    .we    (dec_valid),
    .waddr (dec_rd),
    .wdata (ex_result)
  );

  assign dmem_addr_o  = '0;
  assign dmem_wdata_o = '0;
  assign dmem_we_o    = '0;
  assign unused_dmem  = ^dmem_rdata_i;

endmodule

// File: tb/tb_jedro_1_core.sv
module tb_jedro_1_core;

  logic        clk_i  = 1'b0;
  logic        rstn_i = 1'b1;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_we_o;
  logic [31:0] dmem_rdata_i;
  logic [31:0] rom [64];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk_i = ~clk_i;

  // one-cycle-latency instruction ROM
  always @(posedge clk_i) imem_data_i <= rom[imem_addr_o[7:2]];

  assign dmem_rdata_i = 32'hDEADBEEF;

  jedro_1_core dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .imem_addr_o  (imem_addr_o),
    .imem_data_i  (imem_data_i),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_rdata_i (dmem_rdata_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] rf(input int i);
    return dut.regfile_inst.regfile[i];
  endfunction

  function automatic logic [31:0] illegal();
    return {31'b0, dut.decoder_inst.illegal_instr_ro};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3, input int rd);
    return {imm[11:0], rs1[4:0], f3, rd[4:0], 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_sh(input logic [6:0] f7, input int sh, input int rs1,
                                         input logic [2:0] f3, input int rd);
    return {f7, sh[4:0], rs1[4:0], f3, rd[4:0], 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_lui(input int imm20, input int rd);
    return {imm20[19:0], rd[4:0], 7'b0110111};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
  endtask

  task automatic load_prog_a();
    clear_rom();
    rom[0]  = enc_i(1, 0, 3'b000, 1);                  // addi x1,x0,1
    rom[1]  = enc_sh(7'b0000000, 1, 1, 3'b001, 2);     // slli x2,x1,1
    rom[2]  = enc_sh(7'b0000000, 2, 2, 3'b001, 2);     // slli x2,x2,2
    rom[3]  = enc_sh(7'b0000000, 3, 2, 3'b001, 2);     // slli x2,x2,3
    rom[4]  = enc_i(-8, 0, 3'b000, 3);                 // addi x3,x0,-8
    rom[5]  = enc_sh(7'b0100000, 1, 3, 3'b101, 4);     // srai x4,x3,1
    rom[6]  = enc_sh(7'b0000000, 28, 3, 3'b101, 5);    // srli x5,x3,28
    rom[7]  = enc_i(-1, 0, 3'b000, 6);                 // addi x6,x0,-1
    rom[8]  = enc_i(-1, 0, 3'b011, 7);                 // sltiu x7,x0,-1
    rom[9]  = enc_i(0, 6, 3'b010, 8);                  // slti x8,x6,0
    rom[10] = enc_lui(32'hABCDE, 9);                   // lui x9,0xABCDE
    rom[11] = enc_i(32'h0F0, 6, 3'b100, 11);           // xori x11,x6,0x0F0
    rom[12] = enc_i(32'h7F0, 1, 3'b110, 12);           // ori x12,x1,0x7F0
    rom[13] = enc_i(-16, 6, 3'b111, 13);               // andi x13,x6,-16
    rom[14] = enc_i(-7, 3, 3'b010, 15);                // slti x15,x3,-7
    rom[15] = enc_i(5, 1, 3'b011, 16);                 // sltiu x16,x1,5
    rom[16] = enc_lui(32'h80000, 17);                  // lui x17,0x80000
    rom[17] = enc_i(-1, 17, 3'b000, 17);               // addi x17,x17,-1
    rom[18] = enc_i(5, 0, 3'b000, 0);                  // addi x0,x0,5
    rom[19] = 32'h00000000;                            // illegal
    rom[20] = enc_i(7, 0, 3'b000, 10);                 // squashed
    rom[21] = enc_i(9, 0, 3'b000, 10);                 // squashed
  endtask

  task automatic do_reset();
    rstn_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b0;
  endtask

  task automatic run_to_stop();
    int cyc;
    cyc = 0;
    while (dut.decoder_inst.illegal_instr_ro !== 1'b1 && cyc < 32) begin
      @(posedge clk_i);
      cyc++;
    end
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  task automatic check_prog_a(input string p);
    check({p, "_x0"},  rf(0),  32'h00000000);
    check({p, "_x1"},  rf(1),  32'h00000001);
    check({p, "_x2"},  rf(2),  32'h00000040);
    check({p, "_x3"},  rf(3),  32'hFFFFFFF8);
    check({p, "_x4"},  rf(4),  32'hFFFFFFFC);
    check({p, "_x5"},  rf(5),  32'h0000000F);
    check({p, "_x6"},  rf(6),  32'hFFFFFFFF);
    check({p, "_x7"},  rf(7),  32'h00000001);
    check({p, "_x8"},  rf(8),  32'h00000001);
    check({p, "_x9"},  rf(9),  32'hABCDE000);
    check({p, "_x10"}, rf(10), 32'h00000000);
    check({p, "_x11"}, rf(11), 32'hFFFFFF0F);
    check({p, "_x12"}, rf(12), 32'h000007F1);
    check({p, "_x13"}, rf(13), 32'hFFFFFFF0);
    check({p, "_x15"}, rf(15), 32'h00000001);
    check({p, "_x16"}, rf(16), 32'h00000001);
    check({p, "_x17"}, rf(17), 32'h7FFFFFFF);
    check({p, "_illegal"}, illegal(), 32'h1);
    // illegal word at index 19: PC stops two words later
    check({p, "_pc_frozen"}, imem_addr_o, 32'd84);
  endtask

  initial begin
    load_prog_a();

    // reset state while reset is held
    rstn_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_pc", imem_addr_o, 32'h0);
    check("rst_illegal", illegal(), 32'h0);
    check("rst_valid", {31'b0, dut.decoder_inst.valid_ro}, 32'h0);
    check("rst_x1", rf(1), 32'h0);
    check("rst_dmem_addr", dmem_addr_o, 32'h0);
    check("rst_dmem_wdata", dmem_wdata_o, 32'h0);
    check("rst_dmem_we", {28'b0, dmem_we_o}, 32'h0);

    // full program
    rstn_i = 1'b0;
    run_to_stop();
    check_prog_a("a");
    repeat (4) @(posedge clk_i);
    #1;
    check("a_pc_still", imem_addr_o, 32'd84);
    check("a_x10_still", rf(10), 32'h0);

    // asynchronous reset while the illegal flag is set
    #1 rstn_i = 1'b1;
    #1;
    check("arst_illegal", illegal(), 32'h0);
    check("arst_x2", rf(2), 32'h0);
    check("arst_x9", rf(9), 32'h0);
    check("arst_pc", imem_addr_o, 32'h0);

    // reset in the middle of a running program, then rerun
    do_reset();
    repeat (8) @(posedge clk_i);
    #1;
    check("mid_x1_before", rf(1), 32'h1);
    #2 rstn_i = 1'b1;
    #1;
    check("mid_x1_after", rf(1), 32'h0);
    check("mid_x2_after", rf(2), 32'h0);
    check("mid_pc_after", imem_addr_o, 32'h0);
    @(posedge clk_i);
    #1 rstn_i = 1'b0;
    run_to_stop();
    check_prog_a("rerun");

    // slli with funct7=0100000 is illegal
    clear_rom();
    rom[0] = enc_i(3, 0, 3'b000, 5);                   // addi x5,x0,3
    rom[1] = enc_sh(7'b0100000, 1, 5, 3'b001, 5);      // bad slli x5,x5,1
    rom[2] = enc_i(1, 0, 3'b000, 6);                   // squashed
    do_reset();
    run_to_stop();
    check("bslli_illegal", illegal(), 32'h1);
    check("bslli_x5", rf(5), 32'h00000003);
    check("bslli_x6", rf(6), 32'h0);
    check("bslli_pc", imem_addr_o, 32'd12);

    // unsupported opcode (R-type add) is illegal
    clear_rom();
    rom[0] = enc_i(2, 0, 3'b000, 1);                   // addi x1,x0,2
    rom[1] = 32'h001081B3;                             // add x3,x1,x1
    rom[2] = enc_i(4, 0, 3'b000, 3);                   // squashed
    do_reset();
    run_to_stop();
    check("rtype_illegal", illegal(), 32'h1);
    check("rtype_x1", rf(1), 32'h00000002);
    check("rtype_x3", rf(3), 32'h0);
    check("rtype_pc", imem_addr_o, 32'd12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
